// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 cycle sequencer: T-state bit positions,
// injection causes and the IRQ source index width helper.
package cpu6502_pkg;

    localparam int T0_BIT  = 0;
    localparam int VEC_BIT = 5;

    typedef enum logic [1:0] {
        INJ_NONE  = 2'd0,
        INJ_RESET = 2'd1,
        INJ_NMI   = 2'd2,
        INJ_IRQ   = 2'd3
    } inj_cause_e;

    function automatic int irq_index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cycle_sequencer_6502_chk.sv
// Sequencer checker: the decoder must end every instruction before the
// one-hot T-state register runs off its last bit.
module cycle_sequencer_6502_chk (
    input logic clk,
    input logic rst_n,
    input logic ready_i,
    input logic next_i,
    input logic clear_i,
    input logic last_i
);

    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(ready_i && last_i && !next_i && !clear_i));

endmodule

// File: rtl/int_capture.sv
// NMI falling-edge capture (synchroniser plus 2-flop history) and IRQ
// mask / lowest-index priority encoder.
module int_capture
    import cpu6502_pkg::*;
#(
    parameter int IRQ_CHANNELS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   nnmi_i,
    input  logic                                   nmi_clr_i,
    input  logic [IRQ_CHANNELS-1:0]                nirq_i,
    input  logic [IRQ_CHANNELS-1:0]                irq_mask_i,
    output logic                                   nmi_pending_o,
    output logic                                   irq_any_o,
    output logic [irq_index_w(IRQ_CHANNELS)-1:0]   irq_idx_o
);
    localparam int IW = irq_index_w(IRQ_CHANNELS);

    logic                    nmi_sync_q;
    logic [1:0]              nmi_hist_q;
    logic                    nmi_pending_q;
    logic                    nmi_fall_s;
    logic [IRQ_CHANNELS-1:0] irq_act_s;

    assign nmi_fall_s    = nmi_hist_q[1] & ~nmi_hist_q[0];
    assign irq_act_s     = ~nirq_i & irq_mask_i;
    assign irq_any_o     = |irq_act_s;
    assign nmi_pending_o = nmi_pending_q;

    // Edge capture runs every clock regardless of READY; a new edge beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync_q    <= 1'b1;
            nmi_hist_q    <= 2'b11;
            nmi_pending_q <= 1'b0;
        end else begin
            nmi_sync_q <= nnmi_i;
            nmi_hist_q <= {nmi_hist_q[0], nmi_sync_q};
            if (nmi_fall_s) begin
                nmi_pending_q <= 1'b1;
            end else if (nmi_clr_i) begin
                nmi_pending_q <= 1'b0;
            end else begin
                nmi_pending_q <= nmi_pending_q;
            end
        end
    end

    // Lowest active unmasked channel wins, so scan from the top down.
    always_comb begin
        irq_idx_o = {IW{1'b0}};
        for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
            if (irq_act_s[i]) begin
                irq_idx_o = IW'(i);
            end else begin
                irq_idx_o = irq_idx_o;
            end
        end
    end

endmodule

// File: rtl/cycle_sequencer_6502.sv
// 6502 cycle sequencer: one-hot T-state, SD1/SD2 tail, interrupt/reset BRK
// injection. Define SEQ_WAI_STP_EN to enable the WAI/STP halt states.
module cycle_sequencer_6502
    import cpu6502_pkg::*;
#(
    parameter int T_STATES     = 6,
    parameter int IRQ_CHANNELS = 2
) (
    input  logic                                   clk,
    input  logic                                   nRESET,
    input  logic                                   READY,
    input  logic                                   NEXT_T,
    input  logic                                   CLEAR_T,
    input  logic                                   I_FLAG,
    input  logic                                   nNMI,
    input  logic [IRQ_CHANNELS-1:0]                nIRQ,
    input  logic [IRQ_CHANNELS-1:0]                IRQ_MASK,
    input  logic                                   WAI,
    input  logic                                   STP,
    output logic [T_STATES-1:0]                    T_state,
    output logic                                   SD1,
    output logic                                   SD2,
    output logic                                   SYNC,
    output logic                                   FORCE_BRK,
    output logic                                   nNMI_req,
    output logic                                   nRESET_req,
    output logic [irq_index_w(IRQ_CHANNELS)-1:0]   IRQ_SRC,
    output logic                                   HALTED
);
    localparam int                  IW        = irq_index_w(IRQ_CHANNELS);
    localparam logic [T_STATES-1:0] T0_ONEHOT = {{(T_STATES-1){1'b0}}, 1'b1};

    logic [T_STATES-1:0] t_q, t_d;
    logic                sd1_q, sd1_d, sd2_q, sd2_d, sync_q, sync_d;
    logic                force_brk_q, force_brk_d, nnmi_req_q, nnmi_req_d;
    logic                nreset_req_q, nreset_req_d, halted_q, halted_d, stp_q, stp_d;
    logic [IW-1:0]       irq_src_q, irq_src_d, irq_idx_s;
    logic                nmi_pending_s, irq_any_s, nmi_clr_s, enter_t0_s;
    logic                halt_req_s, wake_s;
    inj_cause_e          cause_s;

    int_capture #(.IRQ_CHANNELS(IRQ_CHANNELS)) u_int_capture (
        .clk           (clk),
        .rst_n         (nRESET),
        .nnmi_i        (nNMI),
        .nmi_clr_i     (nmi_clr_s),
        .nirq_i        (nIRQ),
        .irq_mask_i    (IRQ_MASK),
        .nmi_pending_o (nmi_pending_s),
        .irq_any_o     (irq_any_s),
        .irq_idx_o     (irq_idx_s)
    );

    cycle_sequencer_6502_chk u_chk (
        .clk     (clk),
        .rst_n   (nRESET),
        .ready_i (READY),
        .next_i  (NEXT_T),
        .clear_i (CLEAR_T),
        .last_i  (t_q[T_STATES-1])
    );

`ifdef SEQ_WAI_STP_EN
    // WAI wakes on any request even when I_FLAG masks it; injection then decides.
    assign halt_req_s = t_q[1] & (WAI | STP);
    assign wake_s     = ~stp_q & (nmi_pending_s | irq_any_s);
`else
    logic unused_wai_stp_s;
    assign unused_wai_stp_s = WAI ^ STP ^ stp_q;
    assign halt_req_s       = 1'b0;
    assign wake_s           = 1'b0;
`endif

    // Injection cause in priority order, sampled at the T0->T1 boundary.
    always_comb begin
        if (!nreset_req_q) begin
            cause_s = INJ_RESET;
        end else if (nmi_pending_s) begin
            cause_s = INJ_NMI;
        end else if (irq_any_s && !I_FLAG) begin
            cause_s = INJ_IRQ;
        end else begin
            cause_s = INJ_NONE;
        end
    end

    // Next-state for T-state, SD tail, injection flags and halt.
    always_comb begin
        t_d          = t_q;
        sd1_d        = sd1_q;
        sd2_d        = sd2_q;
        force_brk_d  = force_brk_q;
        nnmi_req_d   = nnmi_req_q;
        nreset_req_d = nreset_req_q;
        irq_src_d    = irq_src_q;
        halted_d     = halted_q;
        stp_d        = stp_q;
        enter_t0_s   = 1'b0;
        nmi_clr_s    = 1'b0;
        if (READY) begin
            nmi_clr_s = t_q[VEC_BIT] & ~nnmi_req_q;
            if (halted_q) begin
                halted_d = ~wake_s;
            end else if (sd1_q) begin
                sd1_d = 1'b0;
                sd2_d = 1'b1;
            end else if (sd2_q) begin
                sd2_d      = 1'b0;
                t_d        = T0_ONEHOT;
                enter_t0_s = 1'b1;
            end else if (halt_req_s) begin
                t_d        = T0_ONEHOT;
                halted_d   = 1'b1;
                stp_d      = STP;
                enter_t0_s = 1'b1;
            end else if (CLEAR_T) begin
                t_d   = {T_STATES{1'b0}};
                sd1_d = 1'b1;
            end else if (NEXT_T || t_q[T_STATES-1]) begin
                t_d        = T0_ONEHOT;
                enter_t0_s = 1'b1;
            end else begin
                t_d = {t_q[T_STATES-2:0], 1'b0};
                if (t_q[T0_BIT]) begin
                    case (cause_s)
                        INJ_RESET: force_brk_d = 1'b1;
                        INJ_NMI: begin
                            force_brk_d = 1'b1;
                            nnmi_req_d  = 1'b0;
                        end
                        INJ_IRQ: begin
                            force_brk_d = 1'b1;
                            irq_src_d   = irq_idx_s;
                        end
                        default: force_brk_d = force_brk_q;
                    endcase
                end else begin
                    force_brk_d = force_brk_q;
                end
            end
            if (enter_t0_s && force_brk_q) begin
                force_brk_d  = 1'b0;
                nnmi_req_d   = 1'b1;
                nreset_req_d = 1'b1;
            end else begin
                force_brk_d = force_brk_d;
            end
        end else begin
            nmi_clr_s = 1'b0;
        end
        sync_d = t_d[T0_BIT] & ~halted_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            t_q          <= T0_ONEHOT;
            sd1_q        <= 1'b0;
            sd2_q        <= 1'b0;
            sync_q       <= 1'b1;
            force_brk_q  <= 1'b0;
            nnmi_req_q   <= 1'b1;
            nreset_req_q <= 1'b0;
            irq_src_q    <= {IW{1'b0}};
            halted_q     <= 1'b0;
            stp_q        <= 1'b0;
        end else begin
            t_q          <= t_d;
            sd1_q        <= sd1_d;
            sd2_q        <= sd2_d;
            sync_q       <= sync_d;
            force_brk_q  <= force_brk_d;
            nnmi_req_q   <= nnmi_req_d;
            nreset_req_q <= nreset_req_d;
            irq_src_q    <= irq_src_d;
            halted_q     <= halted_d;
            stp_q        <= stp_d;
        end
    end

    assign T_state    = t_q;
    assign SD1        = sd1_q;
    assign SD2        = sd2_q;
    assign SYNC       = sync_q;
    assign FORCE_BRK  = force_brk_q;
    assign nNMI_req   = nnmi_req_q;
    assign nRESET_req = nreset_req_q;
    assign IRQ_SRC    = irq_src_q;
    assign HALTED     = halted_q;

endmodule
